// File: rtl/l1_line_biu.sv
// L1-D bus interface unit: single reads/writes, line refill and dirty-line writeback over req/ack/err.
// Optional ack watchdog is enabled by defining L1_BIU_TIMEOUT_EN.
module l1_line_biu #(
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned LINE_WORDS  = 128,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_req,
  input  logic                  write_through_req,
  input  logic                  read_line_req,
  input  logic                  write_line_req,
  input  logic [ADDR_WIDTH-1:0] pa,
  input  logic [DATA_WIDTH-1:0] wt_data,
  output logic [DATA_WIDTH-1:0] line_data,
  output logic [7:0]            addr_count,
  output logic                  line_write,
  output logic                  cache_entry_refill,
  output logic                  trans_rdy,
  output logic                  bus_error,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  input  logic                  bus_err
);

  localparam int unsigned IW         = $clog2(LINE_WORDS);
  localparam int unsigned OB         = $clog2(DATA_WIDTH / 8);
  localparam int unsigned LINE_BYTES = LINE_WORDS * (DATA_WIDTH / 8);

  if (LINE_WORDS < 2 || LINE_WORDS > 128 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("l1_line_biu: unsupported LINE_WORDS or TIMEOUT_CYC");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SINGLE, S_FILL, S_WB_RD, S_WB_WR, S_DONE, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, idx_nxt;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   line_base, word_pa, cur_addr, nxt_addr;
  logic                    last_word, beat_ok, beat_err, timeout_hit;

  logic                    bus_req_d, bus_we_d, line_write_d, refill_d, trans_rdy_d, bus_error_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_d, line_data_d;
  logic [7:0]              addr_count_d;

  function automatic logic [7:0] word_ptr(input logic [IW-1:0] i, input logic ph);
    return 8'({i, ph});
  endfunction

  assign line_base = pa & ~ADDR_WIDTH'(LINE_BYTES - 1);
  assign word_pa   = pa & ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
  assign idx_nxt   = idx_q + IW'(1);
  assign cur_addr  = base_q | (ADDR_WIDTH'(idx_q) << OB);
  assign nxt_addr  = base_q | (ADDR_WIDTH'(idx_nxt) << OB);
  assign last_word = (idx_q == IW'(LINE_WORDS - 1));

  // Handshake is only honoured while a beat is outstanding; err wins over ack.
  assign beat_err = bus_req & (bus_err | timeout_hit);
  assign beat_ok  = bus_req & bus_ack & ~bus_err & ~timeout_hit;

`ifdef L1_BIU_TIMEOUT_EN
  logic [7:0] tmo_q;

  assign timeout_hit = bus_req && (tmo_q == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (!bus_req || bus_ack || bus_err || timeout_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    bus_req_d    = bus_req;
    bus_we_d     = bus_we;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    line_data_d  = line_data;
    addr_count_d = addr_count;
    line_write_d = 1'b0;
    refill_d     = 1'b0;
    trans_rdy_d  = 1'b0;
    bus_error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (write_line_req) begin
          state_d      = S_WB_RD;
          base_d       = line_base;
          addr_count_d = word_ptr('0, 1'b0);
        end else if (read_line_req) begin
          state_d      = S_FILL;
          base_d       = line_base;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = line_base;
          addr_count_d = word_ptr('0, 1'b0);
        end else if (read_req) begin
          state_d    = S_SINGLE;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = word_pa;
        end else if (write_through_req) begin
          state_d     = S_SINGLE;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = word_pa;
          bus_wdata_d = wt_data;
        end
      end

      S_SINGLE: begin
        if (beat_err) begin
          state_d      = S_ERR;
          bus_req_d    = 1'b0;
          bus_error_d  = 1'b1;
          addr_count_d = '0;
        end else if (beat_ok) begin
          bus_req_d   = 1'b0;
          line_data_d = bus_rdata;
          if (bus_we ? write_through_req : read_req) begin
            state_d     = S_DONE;
            trans_rdy_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      // line_write high marks the SRAM write cycle that follows each accepted beat.
      S_FILL: begin
        if (line_write) begin
          idx_d = idx_nxt;
          if (!read_line_req) begin
            state_d = S_IDLE;
          end else if (last_word) begin
            state_d     = S_DONE;
            trans_rdy_d = 1'b1;
            refill_d    = 1'b1;
          end else begin
            bus_req_d    = 1'b1;
            bus_addr_d   = nxt_addr;
            addr_count_d = word_ptr(idx_nxt, 1'b0);
          end
        end else if (beat_err) begin
          state_d      = S_ERR;
          bus_req_d    = 1'b0;
          bus_error_d  = 1'b1;
          addr_count_d = '0;
          idx_d        = '0;
        end else if (beat_ok) begin
          bus_req_d    = 1'b0;
          line_data_d  = bus_rdata;
          line_write_d = 1'b1;
        end
      end

      // SRAM data for addr_count presented in WB_RD is valid when leaving WB_RD.
      S_WB_RD: begin
        state_d      = S_WB_WR;
        bus_req_d    = 1'b1;
        bus_we_d     = 1'b1;
        bus_addr_d   = cur_addr;
        bus_wdata_d  = wt_data;
        addr_count_d = word_ptr(idx_q, 1'b1);
      end

      S_WB_WR: begin
        if (beat_err) begin
          state_d      = S_ERR;
          bus_req_d    = 1'b0;
          bus_error_d  = 1'b1;
          addr_count_d = '0;
          idx_d        = '0;
        end else if (beat_ok) begin
          bus_req_d = 1'b0;
          idx_d     = idx_nxt;
          if (!write_line_req) begin
            state_d = S_IDLE;
          end else if (last_word) begin
            state_d     = S_DONE;
            trans_rdy_d = 1'b1;
          end else begin
            state_d      = S_WB_RD;
            addr_count_d = word_ptr(idx_nxt, 1'b0);
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= S_IDLE;
      idx_q              <= '0;
      base_q             <= '0;
      bus_req            <= 1'b0;
      bus_we             <= 1'b0;
      bus_addr           <= '0;
      bus_wdata          <= '0;
      line_data          <= '0;
      addr_count         <= '0;
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      base_q             <= base_d;
      bus_req            <= bus_req_d;
      bus_we             <= bus_we_d;
      bus_addr           <= bus_addr_d;
      bus_wdata          <= bus_wdata_d;
      line_data          <= line_data_d;
      addr_count         <= addr_count_d;
      line_write         <= line_write_d;
      cache_entry_refill <= refill_d;
      trans_rdy          <= trans_rdy_d;
      bus_error          <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_l1_line_biu.sv
// Directed self-checking bench for l1_line_biu: bus responder, SRAM read model, one task per scenario.
module tb_l1_line_biu;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read_req = 1'b0, write_through_req = 1'b0;
  logic          read_line_req = 1'b0, write_line_req = 1'b0;
  logic [AW-1:0] pa = '0;
  logic [DW-1:0] wt_data, wt_drv = '0;
  logic          wb_mode = 1'b0;
  logic [DW-1:0] line_data, bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic [7:0]    addr_count;
  logic          line_write, cache_entry_refill, trans_rdy, bus_error;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic          bus_ack = 1'b0, bus_err = 1'b0;

  int pass_cnt = 0;
  int check_cnt = 0;

  int resp_on = 1, ack_delay = 0, err_beat = -1;
  int beat_no = 0, wait_cnt = 0;

  always #5 clk = ~clk;

  l1_line_biu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(128), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_req(read_req), .write_through_req(write_through_req),
    .read_line_req(read_line_req), .write_line_req(write_line_req),
    .pa(pa), .wt_data(wt_data), .line_data(line_data), .addr_count(addr_count),
    .line_write(line_write), .cache_entry_refill(cache_entry_refill),
    .trans_rdy(trans_rdy), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {40'hA5A5A5A5A5, a};
  endfunction

  function automatic logic [DW-1:0] sram_word(input logic [6:0] i);
    return 64'h5A5A_0000_0000_0000 | 64'(i);
  endfunction

  // L1 SRAM read port during writeback, otherwise the write-through data.
  assign wt_data = wb_mode ? sram_word(addr_count[7:1]) : wt_drv;

  // Memory responder, driven on the falling edge.
  always @(negedge clk) begin
    if (bus_req && !bus_ack && !bus_err && resp_on != 0) begin
      if (wait_cnt >= ack_delay) begin
        bus_err   = (beat_no == err_beat);
        bus_ack   = (beat_no != err_beat);
        bus_rdata = mem_word(bus_addr);
        wait_cnt  = 0;
        beat_no   = beat_no + 1;
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (!bus_req) wait_cnt = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    check_cnt++;
    if ({bus_req, bus_we, line_write, cache_entry_refill, trans_rdy, bus_error} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus_req, bus_we, line_write, cache_entry_refill, trans_rdy, bus_error});
    else pass_cnt++;
    check_cnt++;
    if ({bus_addr, bus_wdata, line_data, addr_count} !== '0)
      $display("FAIL reset_data: addr %h wdata %h line_data %h addr_count %h want all 0",
               bus_addr, bus_wdata, line_data, addr_count);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) tick();
    check_cnt++;
    if (bus_req !== 1'b0) $display("FAIL idle_no_req: bus_req %b want 0", bus_req);
    else pass_cnt++;
  endtask

  task automatic test_single_read;
    int n;
    pa = 24'h000123; ack_delay = 3; read_req = 1'b1;
    n = 0;
    while (!bus_req && n < 10) begin tick(); n++; end
    check_cnt++;
    if (bus_addr !== 24'h000120 || bus_we !== 1'b0)
      $display("FAIL single_rd_beat: addr %h we %b want 000120 0", bus_addr, bus_we);
    else pass_cnt++;
    n = 0;
    while (!trans_rdy && n < 20) begin tick(); n++; end
    check_cnt++;
    if (trans_rdy !== 1'b1 || line_data !== 64'hA5A5A5A5A5000120 || bus_req !== 1'b0)
      $display("FAIL single_rd_done: rdy %b data %h req %b want 1 a5a5a5a5a5000120 0",
               trans_rdy, line_data, bus_req);
    else pass_cnt++;
    read_req = 1'b0;
    tick();
    check_cnt++;
    if (trans_rdy !== 1'b0) $display("FAIL single_rd_pulse: rdy %b want 0", trans_rdy);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_write_through;
    int n;
    pa = 24'h0000AB; wt_drv = 64'h1122334455667788; ack_delay = 1; write_through_req = 1'b1;
    n = 0;
    while (!bus_req && n < 10) begin tick(); n++; end
    check_cnt++;
    if (bus_addr !== 24'h0000A8 || bus_we !== 1'b1 || bus_wdata !== 64'h1122334455667788)
      $display("FAIL wt_beat: addr %h we %b wdata %h want 0000a8 1 1122334455667788",
               bus_addr, bus_we, bus_wdata);
    else pass_cnt++;
    n = 0;
    while (!trans_rdy && n < 20) begin tick(); n++; end
    check_cnt++;
    if (trans_rdy !== 1'b1) $display("FAIL wt_done: rdy %b want 1", trans_rdy);
    else pass_cnt++;
    write_through_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_refill;
    int n_beats, n_wr, bad_addr, bad_wr, c;
    logic prev_req, done, refill_at_rdy;
    n_beats = 0; n_wr = 0; bad_addr = 0; bad_wr = 0; prev_req = 1'b0; done = 1'b0;
    refill_at_rdy = 1'b0;
    pa = 24'h012345; ack_delay = 0; read_line_req = 1'b1;
    c = 0;
    while (!done && c < 600) begin
      tick(); c++;
      if (bus_req && !prev_req) begin
        if (bus_addr !== 24'h012000 + 24'(8 * n_beats) || bus_we !== 1'b0) bad_addr++;
        n_beats++;
      end
      if (line_write) begin
        if (addr_count[7:1] !== 7'(n_wr) || line_data !== mem_word(24'h012000 + 24'(8 * n_wr)))
          bad_wr++;
        n_wr++;
      end
      if (trans_rdy) begin
        done = 1'b1; refill_at_rdy = cache_entry_refill; read_line_req = 1'b0;
      end
      prev_req = bus_req;
    end
    check_cnt++;
    if (!done) $display("FAIL refill_timeout: no trans_rdy within %0d cycles", c);
    else pass_cnt++;
    check_cnt++;
    if (n_beats != 128 || bad_addr != 0)
      $display("FAIL refill_beats: %0d beats, %0d bad addr, want 128 and 0", n_beats, bad_addr);
    else pass_cnt++;
    check_cnt++;
    if (n_wr != 128 || bad_wr != 0)
      $display("FAIL refill_writes: %0d writes, %0d bad, want 128 and 0", n_wr, bad_wr);
    else pass_cnt++;
    check_cnt++;
    if (refill_at_rdy !== 1'b1) $display("FAIL refill_flag: got %b want 1", refill_at_rdy);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({trans_rdy, cache_entry_refill} !== 2'b00)
      $display("FAIL refill_pulse: rdy/refill %b want 00", {trans_rdy, cache_entry_refill});
    else pass_cnt++;
    tick();
  endtask

  // Writeback and a single read requested together: writeback first, read right after.
  task automatic test_back_to_back;
    int n_wb, bad, n_rdy, c;
    logic prev_req, first_we;
    n_wb = 0; bad = 0; n_rdy = 0; prev_req = 1'b0; first_we = 1'b0;
    pa = 24'h012345; ack_delay = 0; wb_mode = 1'b1;
    write_line_req = 1'b1; read_req = 1'b1;
    c = 0;
    while (n_rdy == 0 && c < 800) begin
      tick(); c++;
      if (bus_req && !prev_req) begin
        if (n_wb == 0) first_we = bus_we;
        if (bus_we !== 1'b1 || bus_addr !== 24'h012000 + 24'(8 * n_wb) ||
            bus_wdata !== sram_word(7'(n_wb)) || addr_count !== 8'(2 * n_wb + 1))
          bad++;
        n_wb++;
      end
      if (trans_rdy) begin n_rdy++; write_line_req = 1'b0; end
      prev_req = bus_req;
    end
    check_cnt++;
    if (first_we !== 1'b1) $display("FAIL arb_wb_first: first beat we %b want 1", first_we);
    else pass_cnt++;
    check_cnt++;
    if (n_wb != 128 || bad != 0)
      $display("FAIL wb_beats: %0d beats, %0d bad, want 128 and 0", n_wb, bad);
    else pass_cnt++;
    wb_mode = 1'b0;
    c = 0;
    while (!bus_req && c < 10) begin tick(); c++; end
    check_cnt++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 24'h012340)
      $display("FAIL b2b_read: req %b we %b addr %h want 1 0 012340", bus_req, bus_we, bus_addr);
    else pass_cnt++;
    c = 0;
    while (!trans_rdy && c < 20) begin tick(); c++; end
    check_cnt++;
    if (trans_rdy !== 1'b1 || line_data !== mem_word(24'h012340))
      $display("FAIL b2b_read_data: rdy %b data %h want 1 %h", trans_rdy, line_data,
               mem_word(24'h012340));
    else pass_cnt++;
    read_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_bus_error;
    int n_wr, n_late_req, c;
    logic seen_err, seen_rdy, seen_refill;
    logic [7:0] ac_at_err;
    n_wr = 0; n_late_req = 0; seen_err = 1'b0; seen_rdy = 1'b0; seen_refill = 1'b0;
    ac_at_err = 8'hFF;
    pa = 24'h012345; ack_delay = 0; err_beat = beat_no + 5; read_line_req = 1'b1;
    c = 0;
    while (!seen_err && c < 100) begin
      tick(); c++;
      if (line_write) n_wr++;
      if (trans_rdy) seen_rdy = 1'b1;
      if (cache_entry_refill) seen_refill = 1'b1;
      if (bus_error) begin seen_err = 1'b1; ac_at_err = addr_count; read_line_req = 1'b0; end
    end
    check_cnt++;
    if (!seen_err || n_wr != 5)
      $display("FAIL err_seen: err %b after %0d writes, want 1 after 5", seen_err, n_wr);
    else pass_cnt++;
    check_cnt++;
    if (ac_at_err !== 8'h00) $display("FAIL err_addr_count: got %h want 00", ac_at_err);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_error !== 1'b0) $display("FAIL err_pulse: bus_error %b want 0", bus_error);
    else pass_cnt++;
    repeat (5) begin
      if (bus_req) n_late_req++;
      if (trans_rdy) seen_rdy = 1'b1;
      if (cache_entry_refill) seen_refill = 1'b1;
      tick();
    end
    check_cnt++;
    if (n_late_req != 0 || seen_rdy || seen_refill)
      $display("FAIL err_quiet: late req %0d rdy %b refill %b want 0 0 0",
               n_late_req, seen_rdy, seen_refill);
    else pass_cnt++;
    err_beat = -1;
  endtask

  task automatic test_reset_mid;
    int n_wr, c;
    n_wr = 0;
    pa = 24'h012345; ack_delay = 2; read_line_req = 1'b1;
    c = 0;
    while (!(n_wr == 10 && bus_req) && c < 200) begin
      tick(); c++;
      if (line_write) n_wr++;
    end
    check_cnt++;
    if (bus_req !== 1'b1 || addr_count !== 8'd20)
      $display("FAIL mid_beat10: req %b addr_count %h want 1 14", bus_req, addr_count);
    else pass_cnt++;
    rst_n = 1'b0; read_line_req = 1'b0;
    tick();
    check_cnt++;
    if ({bus_req, bus_we, line_write, cache_entry_refill, trans_rdy, bus_error} !== 6'b0 ||
        {bus_addr, bus_wdata, line_data, addr_count} !== '0)
      $display("FAIL mid_reset: req %b addr %h line_data %h addr_count %h want all 0",
               bus_req, bus_addr, line_data, addr_count);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    pa = 24'h000040; ack_delay = 0; read_req = 1'b1;
    c = 0;
    while (!trans_rdy && c < 20) begin tick(); c++; end
    check_cnt++;
    if (trans_rdy !== 1'b1 || line_data !== 64'hA5A5A5A5A5000040)
      $display("FAIL post_reset_read: rdy %b data %h want 1 a5a5a5a5a5000040",
               trans_rdy, line_data);
    else pass_cnt++;
    read_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout;
    int n;
    resp_on = 0; pa = 24'h000200; read_req = 1'b1;
    n = 0;
    while (!bus_req && n < 10) begin tick(); n++; end
`ifdef L1_BIU_TIMEOUT_EN
    n = 0;
    while (!bus_error && n < 40) begin tick(); n++; end
    check_cnt++;
    if (bus_error !== 1'b1 || n != 16 || bus_req !== 1'b0)
      $display("FAIL timeout_err: err %b after %0d cycles req %b want 1 16 0", bus_error, n, bus_req);
    else pass_cnt++;
    read_req = 1'b0;
    repeat (2) tick();
`else
    n = 0;
    repeat (300) begin
      if (!bus_req || bus_error) n++;
      tick();
    end
    check_cnt++;
    if (n != 0) $display("FAIL no_timeout: %0d cycles without req, want 0", n);
    else pass_cnt++;
    rst_n = 1'b0; read_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif
    resp_on = 1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_through();
    test_refill();
    test_back_to_back();
    test_bus_error();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
